// File: rtl/reg_file_bus_pkg.sv
// Shared slot map and default widths for the data bus and the register-file block.
// Slot numbers are the bit positions in the read/write/inc/clr select vectors.
package reg_file_bus_pkg;

  localparam int DEFAULT_REG_COUNT = 16;
  localparam int DEFAULT_REG_WIDTH = 12;

  typedef enum logic [3:0] {
    SLOT_AC     = 4'd0,
    SLOT_PC     = 4'd1,
    SLOT_AR     = 4'd2,
    SLOT_IR     = 4'd3,
    SLOT_R      = 4'd4,
    SLOT_ROW    = 4'd5,
    SLOT_CAT    = 4'd6,
    SLOT_CB     = 4'd7,
    SLOT_RNOW   = 4'd8,
    SLOT_CATNOW = 4'd9,
    SLOT_CBNOW  = 4'd10,
    SLOT_ALPHAP = 4'd11,
    SLOT_BETAP  = 4'd12,
    SLOT_GAMMAP = 4'd13,
    SLOT_TOTAL  = 4'd14,
    SLOT_DR     = 4'd15
  } slot_e;

  // AC and DR live outside this block; only the slots in between are stored here.
  localparam int AC_IDX     = int'(SLOT_AC);
  localparam int DR_IDX     = int'(SLOT_DR);
  localparam int FIRST_SLOT = int'(SLOT_PC);
  localparam int LAST_SLOT  = int'(SLOT_TOTAL);

endpackage

// File: rtl/reg_file_bus_if.sv
// Bus-side signals of the register file: select vectors and data in, read data and flags out.
// Selects are sampled on the rising clock edge; Register_file and rd_zero are combinational.
interface reg_file_bus_if #(
  parameter int Reg_count = 16,
  parameter int reg_width = 12
) ();
  logic [reg_width-1:0] bus_in;
  logic [Reg_count-1:0] write_en;
  logic [Reg_count-1:0] inc_en;
  logic [Reg_count-1:0] clr_en;
  logic [Reg_count-1:0] read_en;
  logic [reg_width-1:0] Register_file;
  logic                 rd_zero;
  logic                 wr_err;

  modport master (
    output bus_in, write_en, inc_en, clr_en, read_en,
    input  Register_file, rd_zero, wr_err
  );

  modport slave (
    input  bus_in, write_en, inc_en, clr_en, read_en,
    output Register_file, rd_zero, wr_err
  );
endinterface

// File: rtl/bus_reg_slot.sv
// One bus register with clear > write > increment priority; increment wraps silently.
module bus_reg_slot #(
  parameter int Width = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr,
  input  logic             inc,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (wr)   q <= d;
    else if (inc)  q <= q + Width'(1);
  end

endmodule

// File: rtl/reg_file_bus.sv
// Register file for bus slots PC..Total: write-legality check, per-slot registers,
// and a lowest-index-wins read mux.
module reg_file_bus
  import reg_file_bus_pkg::*;
#(
  parameter int Reg_count = DEFAULT_REG_COUNT,
  parameter int reg_width = DEFAULT_REG_WIDTH
) (
  input logic           clk,
  input logic           reset_n,
  reg_file_bus_if.slave bus
);

  logic [Reg_count-1:0] write_dec;
  logic                 write_legal;
  logic                 wr_err_q;
  logic [reg_width-1:0] regs [FIRST_SLOT:LAST_SLOT];
  logic [reg_width-1:0] rd_val;

  // Clearing the lowest set bit leaves zero only for a zero or one-hot vector.
  assign write_dec   = bus.write_en - {{(Reg_count-1){1'b0}}, 1'b1};
  assign write_legal = (bus.write_en & write_dec) == '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_err_q <= 1'b0;
    else          wr_err_q <= !write_legal;
  end

  for (genvar i = FIRST_SLOT; i <= LAST_SLOT; i++) begin : g_slot
    bus_reg_slot #(.Width(reg_width)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (bus.clr_en[i]),
      .wr      (write_legal & bus.write_en[i]),
      .inc     (bus.inc_en[i]),
      .d       (bus.bus_in),
      .q       (regs[i])
    );
  end

  // Scan high to low so the lowest-numbered selected slot is the one left standing.
  always_comb begin
    rd_val = '0;
    for (int i = LAST_SLOT; i >= FIRST_SLOT; i--) begin
      if (bus.read_en[i]) rd_val = regs[i];
    end
  end

  assign bus.Register_file = rd_val;
  assign bus.rd_zero       = (rd_val == '0);
  assign bus.wr_err        = wr_err_q;

  // AC and DR selects belong to other blocks; they only matter for write legality.
  wire unused_bits = ^{bus.inc_en[AC_IDX], bus.inc_en[DR_IDX],
                       bus.clr_en[AC_IDX], bus.clr_en[DR_IDX],
                       bus.read_en[AC_IDX], bus.read_en[DR_IDX]};

endmodule

// File: tb/tb_reg_file_bus.sv
// Self-checking bench for reg_file_bus: directed vector table, reset sequence,
// then randomized traffic against an array-based model of the slot rules.
module tb_reg_file_bus;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_bus_if #(.Reg_count(16), .reg_width(12)) bus_if ();

  reg_file_bus #(.Reg_count(16), .reg_width(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: slot contents by index, plus the expected error flag.
  int unsigned mdl [16];
  bit          mdl_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) mdl[s] = 0;
    mdl_err = 1'b0;
  endfunction

  function automatic void model_edge(logic [15:0] clr, logic [15:0] wr, logic [15:0] inc,
                                     logic [11:0] din);
    bit legal;
    legal = $countones(wr) <= 1;
    for (int s = 1; s <= 14; s++) begin
      if (clr[s])                mdl[s] = 0;
      else if (legal && wr[s])   mdl[s] = din;
      else if (inc[s])           mdl[s] = (mdl[s] + 1) % 4096;
    end
    mdl_err = !legal;
  endfunction

  function automatic logic [11:0] model_read(logic [15:0] rd);
    for (int s = 1; s <= 14; s++) if (rd[s]) return 12'(mdl[s]);
    return 12'h000;
  endfunction

  task automatic drive(logic [15:0] clr, logic [15:0] wr, logic [15:0] inc,
                       logic [11:0] din, logic [15:0] rd);
    bus_if.clr_en   = clr;
    bus_if.write_en = wr;
    bus_if.inc_en   = inc;
    bus_if.bus_in   = din;
    bus_if.read_en  = rd;
  endtask

  // Called just after a falling edge: drive, sample pre-edge read, cross one
  // rising edge, advance the model, and leave at the next falling edge.
  task automatic step(logic [15:0] clr, logic [15:0] wr, logic [15:0] inc,
                      logic [11:0] din, logic [15:0] rd, output logic [11:0] pre_rf);
    drive(clr, wr, inc, din, rd);
    #1;
    pre_rf = bus_if.Register_file;
    @(posedge clk);
    model_edge(clr, wr, inc, din);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [15:0] clr;
    logic [15:0] wr;
    logic [15:0] inc;
    logic [11:0] din;
    logic [15:0] rd;
    logic [11:0] exp_pre;
    logic [11:0] exp_post;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [11:0] pre_rf;
  logic [15:0] r_clr, r_wr, r_inc, r_rd;
  logic [11:0] r_din, exp_pre;

  initial begin
    //                clr      wr       inc      din     rd       pre     post    err
    vecs[0]  = '{16'h0000, 16'h0004, 16'h0000, 12'h123, 16'h0004, 12'h000, 12'h123, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0002, 16'h0000, 12'hFFF, 16'h0002, 12'h000, 12'hFFF, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0000, 16'h0002, 12'h000, 16'h0002, 12'hFFF, 12'h000, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0008, 16'h0000, 12'h055, 16'h0008, 12'h000, 12'h055, 1'b0};
    vecs[4]  = '{16'h0008, 16'h0008, 16'h0008, 12'h777, 16'h0008, 12'h055, 12'h000, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0008, 16'h0008, 12'h777, 16'h0008, 12'h000, 12'h777, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0020, 16'h0000, 12'h010, 16'h0020, 12'h000, 12'h010, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0006, 16'h0020, 12'h3C3, 16'h0020, 12'h010, 12'h011, 1'b1};
    vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 12'h3C3, 16'h0004, 12'h123, 12'h123, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 16'h0000, 12'h000, 16'h0002, 12'h000, 12'h000, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 16'h0000, 12'h000, 16'h8001, 12'h000, 12'h000, 1'b0};
    vecs[11] = '{16'h0000, 16'h0010, 16'h0000, 12'h0AA, 16'h0030, 12'h000, 12'h0AA, 1'b0};
    vecs[12] = '{16'h0000, 16'h0000, 16'h0000, 12'h000, 16'h0030, 12'h0AA, 12'h0AA, 1'b0};
    vecs[13] = '{16'h0000, 16'h8000, 16'h0000, 12'h5A5, 16'h0030, 12'h0AA, 12'h0AA, 1'b0};
    vecs[14] = '{16'h0000, 16'h0001, 16'h0000, 12'h5A5, 16'h7FFE, 12'h000, 12'h000, 1'b0};
    vecs[15] = '{16'h0000, 16'h0002, 16'h0004, 12'h050, 16'h0004, 12'h123, 12'h124, 1'b0};
    vecs[16] = '{16'h0000, 16'h0000, 16'h0000, 12'h000, 16'h0002, 12'h050, 12'h050, 1'b0};

    // Reset state
    model_reset();
    drive(16'h0, 16'h0, 16'h0, 12'h0, 16'h0002);
    repeat (2) @(negedge clk);
    check("reset_rf", 32'(bus_if.Register_file), 32'h000);
    check("reset_rd_zero", 32'(bus_if.rd_zero), 32'h1);
    check("reset_wr_err", 32'(bus_if.wr_err), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int v = 0; v < NVEC; v++) begin
      step(vecs[v].clr, vecs[v].wr, vecs[v].inc, vecs[v].din, vecs[v].rd, pre_rf);
      check($sformatf("vec%0d_pre_rf", v), 32'(pre_rf), 32'(vecs[v].exp_pre));
      check($sformatf("vec%0d_post_rf", v), 32'(bus_if.Register_file), 32'(vecs[v].exp_post));
      check($sformatf("vec%0d_rd_zero", v), 32'(bus_if.rd_zero),
            32'(vecs[v].exp_post == 12'h000));
      check($sformatf("vec%0d_wr_err", v), 32'(bus_if.wr_err), 32'(vecs[v].exp_err));
    end

    // Illegal write leaves both targeted slots untouched; model agrees with table
    step(16'h0, 16'h0006, 16'h0, 12'hEEE, 16'h0004, pre_rf);
    check("illegal_wr_err", 32'(bus_if.wr_err), 32'h1);
    check("illegal_slot2", 32'(bus_if.Register_file), 32'h124);
    drive(16'h0, 16'h0, 16'h0, 12'h0, 16'h0002);
    #1;
    check("illegal_slot1", 32'(bus_if.Register_file), 32'h050);

    // Asynchronous reset mid-cycle while wr_err is high and a write is pending
    drive(16'h0, 16'h0002, 16'h0, 12'hABC, 16'h0002);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rf", 32'(bus_if.Register_file), 32'h000);
    check("async_rd_zero", 32'(bus_if.rd_zero), 32'h1);
    check("async_wr_err", 32'(bus_if.wr_err), 32'h0);
    model_reset();
    @(negedge clk);
    for (int s = 1; s <= 14; s++) begin
      bus_if.read_en = 16'(1) << s;
      #1;
      check($sformatf("reset_slot%0d", s), 32'(bus_if.Register_file), 32'h000);
    end
    @(negedge clk);
    check("held_in_reset", 32'(bus_if.Register_file), 32'h000);
    reset_n = 1'b1;
    step(16'h0, 16'h0002, 16'h0, 12'hABC, 16'h0002, pre_rf);
    check("post_reset_pre", 32'(pre_rf), 32'h000);
    check("post_reset_first_write", 32'(bus_if.Register_file), 32'hABC);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       r_wr = 16'h0000;
        1, 2:    r_wr = 16'(1) << $urandom_range(0, 15);
        default: r_wr = 16'($urandom);
      endcase
      r_clr = 16'($urandom & $urandom & $urandom);
      r_inc = 16'($urandom);
      r_din = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      r_rd  = $urandom_range(0, 1) ? (16'(1) << $urandom_range(0, 15)) : 16'($urandom);
      exp_pre = model_read(r_rd);
      step(r_clr, r_wr, r_inc, r_din, r_rd, pre_rf);
      check("rand_pre_rf", 32'(pre_rf), 32'(exp_pre));
      check("rand_post_rf", 32'(bus_if.Register_file), 32'(model_read(r_rd)));
      check("rand_rd_zero", 32'(bus_if.rd_zero), 32'(model_read(r_rd) == 12'h000));
      check("rand_wr_err", 32'(bus_if.wr_err), 32'(mdl_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
